// File: rtl/xfer_pkg.sv
// Shared types for the transfer controller: FSM states, completion codes and
// the saturating beat-count helper.
package xfer_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACTIVE   = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_REPORT   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ST_OK      = 3'd0,
        ST_ERR     = 3'd1,
        ST_ABORT   = 3'd2,
        ST_OVERRUN = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_PROTO   = 3'd5
    } status_t;

    localparam int unsigned CNT_W = 8;

    // Next beat count, pinned at the ceiling so the counter never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] ceiling);
        if (cnt >= ceiling) begin
            return ceiling;
        end
        return cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/xfer_ctrl_wd_timer.sv
// Watchdog cycle counter: expired is high during the limit-th enabled cycle
// since the last clear, and the count parks there instead of wrapping.
module wd_timer
    import xfer_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // One bit wider so count+1 cannot overflow before the compare.
    assign expired = enable && (({1'b0, cnt_q} + (W+1)'(1)) >= {1'b0, limit});

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xfer_ctrl.sv
// Transfer controller: counts upstream beats, requests downstream completion,
// and reports a one-cycle status code when each transfer ends.
module xfer_ctrl
    import xfer_pkg::*;
#(
    parameter int unsigned MAX_BEATS   = 16,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RDY,
    input  logic       START,
    input  logic       ENDD,
    input  logic       ER,
    input  logic       STOP,
    input  logic       ACK,
    output logic       ENABLE,
    output logic       REQ,
    output logic [7:0] BEAT_CNT,
    output logic       STATUS_VALID,
    output logic [2:0] STATUS,
    output logic       INTERRUPT
);

    localparam logic [CNT_W-1:0] MAX_B = MAX_BEATS[CNT_W-1:0];
    localparam logic [CNT_W-1:0] TO_B  = ACK_TIMEOUT[CNT_W-1:0];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] cnt_inc;
    status_t          code_d;
    status_t          status_q;
    logic             enable_q, req_q, status_valid_q, interrupt_q;
    logic             in_wait;
    logic             ack_expired;

    assign in_wait = (state_q == S_WAIT_ACK);
    assign cnt_inc = sat_inc(beat_q, MAX_B);

    // Held in clear outside WAIT_ACK, so every WAIT_ACK visit starts from zero.
    wd_timer #(
        .W(CNT_W)
    ) u_wd_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_wait),
        .enable (in_wait),
        .limit  (TO_B),
        .expired(ack_expired)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        code_d  = ST_OK;
        case (state_q)
            S_IDLE: begin
                beat_d = '0;
                if (START && RDY) begin
                    state_d = S_ACTIVE;
                    beat_d  = CNT_W'(1);
                end else if (START) begin
                    state_d = S_REPORT;
                    code_d  = ST_PROTO;
                end
            end
            S_ACTIVE: begin
                // Error and abort drop a coincident beat; an end marker keeps it.
                if (ER) begin
                    state_d = S_REPORT;
                    code_d  = ST_ERR;
                end else if (STOP) begin
                    state_d = S_REPORT;
                    code_d  = ST_ABORT;
                end else if (ENDD) begin
                    state_d = S_WAIT_ACK;
                    if (RDY) begin
                        beat_d = cnt_inc;
                    end
                end else if (RDY) begin
                    beat_d = cnt_inc;
                    if (cnt_inc == MAX_B) begin
                        state_d = S_REPORT;
                        code_d  = ST_OVERRUN;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (ER) begin
                    state_d = S_REPORT;
                    code_d  = ST_ERR;
                end else if (ACK) begin
                    state_d = S_REPORT;
                    code_d  = ST_OK;
                end else if (ack_expired) begin
                    state_d = S_REPORT;
                    code_d  = ST_TIMEOUT;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            beat_q         <= '0;
            enable_q       <= 1'b0;
            req_q          <= 1'b0;
            status_valid_q <= 1'b0;
            status_q       <= ST_OK;
            interrupt_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            enable_q       <= (state_d == S_ACTIVE);
            req_q          <= (state_d == S_WAIT_ACK);
            status_valid_q <= (state_d == S_REPORT);
            status_q       <= (state_d == S_REPORT) ? code_d : ST_OK;
            interrupt_q    <= (state_d == S_REPORT) && (code_d != ST_OK);
        end
    end

    assign ENABLE       = enable_q;
    assign REQ          = req_q;
    assign BEAT_CNT     = beat_q;
    assign STATUS_VALID = status_valid_q;
    assign STATUS       = status_q;
    assign INTERRUPT    = interrupt_q;

endmodule

// File: tb/tb_xfer_ctrl.sv
// Table-driven check of xfer_ctrl: one instance at default limits, one with
// MAX_BEATS=4; expected outputs flow through a scoreboard queue.
module tb_xfer_ctrl;
    import xfer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rdy, start, endd, er, stop, ack;

    logic       en_m, req_m, sv_m, int_m;
    logic [7:0] bc_m;
    logic [2:0] st_m;
    logic       en_4, req_4, sv_4, int_4;
    logic [7:0] bc_4;
    logic [2:0] st_4;

    xfer_ctrl #(.MAX_BEATS(16), .ACK_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .RDY(rdy), .START(start), .ENDD(endd),
        .ER(er), .STOP(stop), .ACK(ack),
        .ENABLE(en_m), .REQ(req_m), .BEAT_CNT(bc_m),
        .STATUS_VALID(sv_m), .STATUS(st_m), .INTERRUPT(int_m)
    );

    xfer_ctrl #(.MAX_BEATS(4), .ACK_TIMEOUT(8)) dut4 (
        .clk(clk), .rst(rst), .RDY(rdy), .START(start), .ENDD(endd),
        .ER(er), .STOP(stop), .ACK(ack),
        .ENABLE(en_4), .REQ(req_4), .BEAT_CNT(bc_4),
        .STATUS_VALID(sv_4), .STATUS(st_4), .INTERRUPT(int_4)
    );

    // Input bit order: {rst, start, rdy, endd, er, stop, ack}
    localparam logic [6:0] R0  = 7'b0000000;
    localparam logic [6:0] N   = 7'b1000000;
    localparam logic [6:0] S   = 7'b0100000;
    localparam logic [6:0] RD  = 7'b0010000;
    localparam logic [6:0] E   = 7'b0001000;
    localparam logic [6:0] ERR = 7'b0000100;
    localparam logic [6:0] STP = 7'b0000010;
    localparam logic [6:0] A   = 7'b0000001;

    typedef struct {
        byte         tag;
        int          idx;
        bit          sel;      // 0: default instance, 1: MAX_BEATS=4 instance
        logic [6:0]  in;
        logic [14:0] exp_o;    // {en, req, beat[7:0], sv, status[2:0], intr}
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    byte  cur_tag;
    int   cur_idx;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic seq(input byte t);
        cur_tag = t;
        cur_idx = 0;
    endtask

    task automatic add(input bit sel, input logic [6:0] in, input logic en,
                       input logic req, input int bc, input logic sv,
                       input int st, input logic intr);
        vec_t v;
        v.tag   = cur_tag;
        v.idx   = cur_idx;
        v.sel   = sel;
        v.in    = in;
        v.exp_o = {en, req, bc[7:0], sv, st[2:0], intr};
        tbl.push_back(v);
        cur_idx++;
    endtask

    task automatic idle_row(input bit sel);
        add(sel, N, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vec_t        v;
        logic [14:0] got;

        {rst, start, rdy, endd, er, stop, ack} = R0;

        // Reset state
        seq("R");
        add(0, R0, 0, 0, 0, 0, 0, 0);
        add(0, R0, 0, 0, 0, 0, 0, 0);
        // Five-beat transfer, ACK two cycles after REQ, then a stray ACK in IDLE
        seq("A");
        add(0, N|S|RD, 1, 0, 1, 0, 0, 0);
        add(0, N|RD,   1, 0, 2, 0, 0, 0);
        add(0, N|RD,   1, 0, 3, 0, 0, 0);
        add(0, N|RD,   1, 0, 4, 0, 0, 0);
        add(0, N|RD|E, 0, 1, 5, 0, 0, 0);
        add(0, N,      0, 1, 5, 0, 0, 0);
        add(0, N|A,    0, 0, 5, 1, 0, 0);
        add(0, N|A,    0, 0, 0, 0, 0, 0);
        // ER with ENDD and RDY: error wins, beat dropped, REQ never raised
        seq("B");
        add(0, N|S|RD,       1, 0, 1, 0, 0, 0);
        add(0, N|RD,         1, 0, 2, 0, 0, 0);
        add(0, N|RD|ERR|E,   0, 0, 2, 1, 1, 1);
        idle_row(0);
        // ACK timeout: REQ high exactly 8 cycles; START ignored while waiting
        seq("C");
        add(0, N|S|RD, 1, 0, 1, 0, 0, 0);
        add(0, N|E,    0, 1, 1, 0, 0, 0);
        add(0, N|S|RD, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, N, 0, 1, 1, 0, 0, 0);
        add(0, N,      0, 0, 1, 1, 4, 1);
        idle_row(0);
        // START without RDY in IDLE
        seq("D");
        add(0, N|S, 0, 0, 0, 1, 5, 1);
        idle_row(0);
        // START ignored in ACTIVE; STOP drops its coincident beat
        seq("E");
        add(0, N|S|RD,     1, 0, 1, 0, 0, 0);
        add(0, N|S|RD,     1, 0, 2, 0, 0, 0);
        add(0, N|STP|RD,   0, 0, 2, 1, 2, 1);
        idle_row(0);
        // ER beats ACK in WAIT_ACK
        seq("F");
        add(0, N|S|RD,  1, 0, 1, 0, 0, 0);
        add(0, N|E|RD,  0, 1, 2, 0, 0, 0);
        add(0, N|ERR|A, 0, 0, 2, 1, 1, 1);
        idle_row(0);
        // ER outranks STOP
        seq("H");
        add(0, N|S|RD,       1, 0, 1, 0, 0, 0);
        add(0, N|ERR|STP|RD, 0, 0, 1, 1, 1, 1);
        idle_row(0);
        // ACK on the last cycle before timeout still completes OK
        seq("T");
        add(0, N|S|RD, 1, 0, 1, 0, 0, 0);
        add(0, N|E,    0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(0, N, 0, 1, 1, 0, 0, 0);
        add(0, N|A,    0, 0, 1, 1, 0, 0);
        idle_row(0);
        // Reset during WAIT_ACK abandons the transfer silently
        seq("G");
        add(0, N|S|RD, 1, 0, 1, 0, 0, 0);
        add(0, N|E,    0, 1, 1, 0, 0, 0);
        add(0, R0,     0, 0, 0, 0, 0, 0);
        idle_row(0);
        // Overrun on the 4th beat with MAX_BEATS=4
        seq("M");
        add(1, R0,     0, 0, 0, 0, 0, 0);
        add(1, N|S|RD, 1, 0, 1, 0, 0, 0);
        add(1, N|RD,   1, 0, 2, 0, 0, 0);
        add(1, N|RD,   1, 0, 3, 0, 0, 0);
        add(1, N|RD,   0, 0, 4, 1, 3, 1);
        idle_row(1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            {rst, start, rdy, endd, er, stop, ack} = tbl[i].in;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            v   = sb.pop_front();
            got = v.sel ? {en_4, req_4, bc_4, sv_4, st_4, int_4}
                        : {en_m, req_m, bc_m, sv_m, st_m, int_m};
            n_cmp++;
            if (got !== v.exp_o) begin
                n_bad++;
                $display("FAIL vec %c%0d: got en=%b req=%b beat=%0d sv=%b st=%0d int=%b, want en=%b req=%b beat=%0d sv=%b st=%0d int=%b",
                         v.tag, v.idx, got[14], got[13], got[12:5], got[4], got[3:1], got[0],
                         v.exp_o[14], v.exp_o[13], v.exp_o[12:5], v.exp_o[4], v.exp_o[3:1], v.exp_o[0]);
            end else begin
                $display("vec %c%0d in=%b en=%b req=%b beat=%0d sv=%b st=%0d int=%b",
                         v.tag, v.idx, v.in, got[14], got[13], got[12:5], got[4], got[3:1], got[0]);
            end
        end

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
